// File: rtl/pin_entry_display_buffer_if.sv
// Signal bundle between keypad decoder, PIN entry buffer, 7-seg controller and lock FSM.
interface pin_entry_display_buffer_if;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned PKT_W  = 24;
  localparam int unsigned LEN_W  = 3;

  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              entry_en;
  logic [PKT_W-1:0]  bcd_packet;
  logic              disp_en;
  logic [PKT_W-1:0]  pin_code;
  logic [LEN_W-1:0]  pin_len;
  logic              pin_valid;
  logic              pin_reject;
  logic              timeout;

  // Keypad / system side: supplies keys, observes display and PIN outputs.
  modport master (
    output key_valid, key_code, entry_en,
    input  bcd_packet, disp_en, pin_code, pin_len, pin_valid, pin_reject, timeout
  );

  // PIN entry buffer side.
  modport slave (
    input  key_valid, key_code, entry_en,
    output bcd_packet, disp_en, pin_code, pin_len, pin_valid, pin_reject, timeout
  );
endinterface

// File: rtl/pin_entry_display_buffer.sv
// Keypad PIN-entry buffer: collects up to six digits, drives a masked BCD
// display packet and hands the raw PIN to the lock FSM on ENTER.
module pin_entry_display_buffer #(
  parameter int unsigned MIN_DIGITS     = 4,
  parameter int unsigned MASK_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  pin_entry_display_buffer_if.slave bus
);

  localparam int unsigned NDIG   = 6;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PKT_W  = NDIG * NIB_W;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned MASK_W = (MASK_CYCLES > 1) ? $clog2(MASK_CYCLES) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [MASK_W-1:0] MASK_LAST = MASK_W'(MASK_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_DIGITS);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(NDIG);
  localparam logic [PKT_W-1:0]  BLANK_PKT = '1;

  localparam logic [NIB_W-1:0] GLYPH_MASK = 4'hA;
  localparam logic [NIB_W-1:0] KEY_LAST_DIGIT = 4'h9;
  localparam logic [NIB_W-1:0] KEY_BKSP   = 4'hA;
  localparam logic [NIB_W-1:0] KEY_CLEAR  = 4'hB;
  localparam logic [NIB_W-1:0] KEY_ENTER  = 4'hC;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ENTRY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [PKT_W-1:0]  raw_q, raw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              show_raw_q, show_raw_d;
  logic [MASK_W-1:0] mask_ctr_q, mask_ctr_d;
  logic [TMO_W-1:0]  idle_ctr_q, idle_ctr_d;
  logic [PKT_W-1:0]  bcd_q, bcd_d;
  logic              disp_en_q;
  logic [PKT_W-1:0]  pin_code_q, pin_code_d;
  logic [CNT_W-1:0]  pin_len_q, pin_len_d;
  logic              pin_valid_q, pin_valid_d;
  logic              pin_reject_q, pin_reject_d;
  logic              timeout_q, timeout_d;
  logic              key_acc_c;
  logic              clear_entry;

  // Keys are only taken while entry is enabled; codes D-F are dropped.
  assign key_acc_c = bus.entry_en && bus.key_valid && (bus.key_code <= KEY_ENTER);

  // Next-state logic: key handling, mask timer and inactivity timeout.
  always_comb begin
    state_d      = state_q;
    raw_d        = raw_q;
    cnt_d        = cnt_q;
    show_raw_d   = show_raw_q;
    mask_ctr_d   = mask_ctr_q;
    idle_ctr_d   = idle_ctr_q;
    pin_code_d   = pin_code_q;
    pin_len_d    = pin_len_q;
    pin_valid_d  = 1'b0;
    pin_reject_d = 1'b0;
    timeout_d    = 1'b0;
    clear_entry  = 1'b0;

    if (bus.entry_en) begin
      if (show_raw_q) begin
        if (mask_ctr_q == MASK_LAST) begin
          show_raw_d = 1'b0;
          mask_ctr_d = '0;
        end else begin
          mask_ctr_d = mask_ctr_q + 1'b1;
        end
      end

      if (key_acc_c) begin
        idle_ctr_d = '0;
        if (bus.key_code <= KEY_LAST_DIGIT) begin
          if (cnt_q < MAX_CNT) begin
            raw_d      = {bus.key_code, raw_q[PKT_W-1:NIB_W]};
            cnt_d      = cnt_q + 1'b1;
            show_raw_d = 1'b1;
            mask_ctr_d = '0;
            state_d    = S_ENTRY;
          end
        end else begin
          case (bus.key_code)
            KEY_BKSP: begin
              if (cnt_q != '0) begin
                raw_d      = {raw_q[PKT_W-NIB_W-1:0], 4'hF};
                cnt_d      = cnt_q - 1'b1;
                show_raw_d = 1'b0;
                mask_ctr_d = '0;
                if (cnt_q == CNT_W'(1)) begin
                  state_d = S_IDLE;
                end
              end
            end
            KEY_CLEAR: begin
              clear_entry = 1'b1;
            end
            KEY_ENTER: begin
              if (cnt_q != '0) begin
                if (cnt_q >= MIN_CNT) begin
                  pin_valid_d = 1'b1;
                  pin_code_d  = raw_q;
                  pin_len_d   = cnt_q;
                  clear_entry = 1'b1;
                end else begin
                  pin_reject_d = 1'b1;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end else if (state_q == S_ENTRY) begin
        if (idle_ctr_q == TMO_LAST) begin
          timeout_d   = 1'b1;
          clear_entry = 1'b1;
        end else begin
          idle_ctr_d = idle_ctr_q + 1'b1;
        end
      end
    end

    if (clear_entry) begin
      state_d    = S_IDLE;
      raw_d      = BLANK_PKT;
      cnt_d      = '0;
      show_raw_d = 1'b0;
      mask_ctr_d = '0;
      idle_ctr_d = '0;
    end
  end

  // Display glyphs: newest digit raw while unmasked, other present digits dashed, rest blank.
  always_comb begin
    bcd_d = BLANK_PKT;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (CNT_W'(i) < cnt_d) begin
        if ((i == 0) && show_raw_d) begin
          bcd_d[PKT_W-1-NIB_W*i -: NIB_W] = raw_d[PKT_W-1 -: NIB_W];
        end else begin
          bcd_d[PKT_W-1-NIB_W*i -: NIB_W] = GLYPH_MASK;
        end
      end
    end
  end

  // State and output registers; reset discards any entry immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      raw_q        <= BLANK_PKT;
      cnt_q        <= '0;
      show_raw_q   <= 1'b0;
      mask_ctr_q   <= '0;
      idle_ctr_q   <= '0;
      bcd_q        <= BLANK_PKT;
      disp_en_q    <= 1'b0;
      pin_code_q   <= BLANK_PKT;
      pin_len_q    <= '0;
      pin_valid_q  <= 1'b0;
      pin_reject_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      raw_q        <= raw_d;
      cnt_q        <= cnt_d;
      show_raw_q   <= show_raw_d;
      mask_ctr_q   <= mask_ctr_d;
      idle_ctr_q   <= idle_ctr_d;
      bcd_q        <= bcd_d;
      disp_en_q    <= 1'b1;
      pin_code_q   <= pin_code_d;
      pin_len_q    <= pin_len_d;
      pin_valid_q  <= pin_valid_d;
      pin_reject_q <= pin_reject_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.bcd_packet = bcd_q;
  assign bus.disp_en    = disp_en_q;
  assign bus.pin_code   = pin_code_q;
  assign bus.pin_len    = pin_len_q;
  assign bus.pin_valid  = pin_valid_q;
  assign bus.pin_reject = pin_reject_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_pin_entry_display_buffer.sv
// Directed self-checking bench for pin_entry_display_buffer (MIN=4, MASK=4, TIMEOUT=20).
module tb_pin_entry_display_buffer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pin_entry_display_buffer_if bus();

  pin_entry_display_buffer #(
    .MIN_DIGITS     (4),
    .MASK_CYCLES    (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle key strobe; returns just after the edge that sampled it.
  task automatic press(input logic [3:0] code);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.bcd_packet !== 24'hFFFFFF) begin errors++; $display("FAIL reset_bcd got %h want %h", bus.bcd_packet, 24'hFFFFFF); end
    checks++; if (bus.disp_en !== 1'b0) begin errors++; $display("FAIL reset_disp_en got %b want 0", bus.disp_en); end
    checks++; if (bus.pin_code !== 24'hFFFFFF) begin errors++; $display("FAIL reset_pin_code got %h want %h", bus.pin_code, 24'hFFFFFF); end
    checks++; if (bus.pin_len !== 3'd0) begin errors++; $display("FAIL reset_pin_len got %0d want 0", bus.pin_len); end
    checks++; if ({bus.pin_valid, bus.pin_reject, bus.timeout} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {bus.pin_valid, bus.pin_reject, bus.timeout}); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.disp_en !== 1'b1) begin errors++; $display("FAIL first_cycle_disp_en got %b want 1", bus.disp_en); end
    checks++; if (bus.bcd_packet !== 24'hFFFFFF) begin errors++; $display("FAIL first_cycle_bcd got %h want %h", bus.bcd_packet, 24'hFFFFFF); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.disp_en, bus.pin_valid, bus.pin_reject, bus.timeout} !== 4'b1000) begin errors++; $display("FAIL idle_quiet cycle %0d got %b want 1000", i, {bus.disp_en, bus.pin_valid, bus.pin_reject, bus.timeout}); end
    end
  endtask

  task automatic test_valid_pin();
    press(4'd1);
    checks++; if (bus.bcd_packet !== 24'h1FFFFF) begin errors++; $display("FAIL vp_key1 got %h want %h", bus.bcd_packet, 24'h1FFFFF); end
    press(4'd2);
    checks++; if (bus.bcd_packet !== 24'h2AFFFF) begin errors++; $display("FAIL vp_key2 got %h want %h", bus.bcd_packet, 24'h2AFFFF); end
    press(4'd3);
    checks++; if (bus.bcd_packet !== 24'h3AAFFF) begin errors++; $display("FAIL vp_key3 got %h want %h", bus.bcd_packet, 24'h3AAFFF); end
    press(4'd4);
    checks++; if (bus.bcd_packet !== 24'h4AAAFF) begin errors++; $display("FAIL vp_key4 got %h want %h", bus.bcd_packet, 24'h4AAAFF); end
    idle(3);
    checks++; if (bus.bcd_packet !== 24'h4AAAFF) begin errors++; $display("FAIL vp_raw_hold got %h want %h", bus.bcd_packet, 24'h4AAAFF); end
    tick();
    checks++; if (bus.bcd_packet !== 24'hAAAAFF) begin errors++; $display("FAIL vp_masked got %h want %h", bus.bcd_packet, 24'hAAAAFF); end
    press(4'hC);
    checks++; if (bus.pin_valid !== 1'b1) begin errors++; $display("FAIL vp_pin_valid got %b want 1", bus.pin_valid); end
    checks++; if (bus.pin_code !== 24'h4321FF) begin errors++; $display("FAIL vp_pin_code got %h want %h", bus.pin_code, 24'h4321FF); end
    checks++; if (bus.pin_len !== 3'd4) begin errors++; $display("FAIL vp_pin_len got %0d want 4", bus.pin_len); end
    checks++; if (bus.bcd_packet !== 24'hFFFFFF) begin errors++; $display("FAIL vp_blank got %h want %h", bus.bcd_packet, 24'hFFFFFF); end
    tick();
    checks++; if (bus.pin_valid !== 1'b0) begin errors++; $display("FAIL vp_pulse_once got %b want 0", bus.pin_valid); end
    checks++; if ({bus.pin_code, bus.pin_len} !== {24'h4321FF, 3'd4}) begin errors++; $display("FAIL vp_pin_hold got %h/%0d want 4321ff/4", bus.pin_code, bus.pin_len); end
  endtask

  task automatic test_reject_backspace();
    press(4'd7);
    press(4'd8);
    checks++; if (bus.bcd_packet !== 24'h8AFFFF) begin errors++; $display("FAIL rj_keys got %h want %h", bus.bcd_packet, 24'h8AFFFF); end
    idle(4);
    press(4'hC);
    checks++; if (bus.pin_reject !== 1'b1) begin errors++; $display("FAIL rj_pulse got %b want 1", bus.pin_reject); end
    checks++; if (bus.pin_valid !== 1'b0) begin errors++; $display("FAIL rj_no_valid got %b want 0", bus.pin_valid); end
    checks++; if (bus.bcd_packet !== 24'hAAFFFF) begin errors++; $display("FAIL rj_kept got %h want %h", bus.bcd_packet, 24'hAAFFFF); end
    tick();
    checks++; if (bus.pin_reject !== 1'b0) begin errors++; $display("FAIL rj_pulse_once got %b want 0", bus.pin_reject); end
    checks++; if ({bus.pin_code, bus.pin_len} !== {24'h4321FF, 3'd4}) begin errors++; $display("FAIL rj_pin_hold got %h/%0d want 4321ff/4", bus.pin_code, bus.pin_len); end
    press(4'hA);
    checks++; if (bus.bcd_packet !== 24'hAFFFFF) begin errors++; $display("FAIL bs_one got %h want %h", bus.bcd_packet, 24'hAFFFFF); end
    press(4'hA);
    checks++; if (bus.bcd_packet !== 24'hFFFFFF) begin errors++; $display("FAIL bs_empty got %h want %h", bus.bcd_packet, 24'hFFFFFF); end
    press(4'hC);
    checks++; if ({bus.pin_valid, bus.pin_reject} !== 2'b00) begin errors++; $display("FAIL bs_idle_enter got %b want 00", {bus.pin_valid, bus.pin_reject}); end
  endtask

  task automatic test_full_entry();
    for (int d = 1; d <= 7; d++) press(4'(d));
    checks++; if (bus.bcd_packet !== 24'h6AAAAA) begin errors++; $display("FAIL full_bcd got %h want %h", bus.bcd_packet, 24'h6AAAAA); end
    press(4'hC);
    checks++; if (bus.pin_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", bus.pin_valid); end
    checks++; if (bus.pin_code !== 24'h654321) begin errors++; $display("FAIL full_pin_code got %h want %h", bus.pin_code, 24'h654321); end
    checks++; if (bus.pin_len !== 3'd6) begin errors++; $display("FAIL full_pin_len got %0d want 6", bus.pin_len); end
    tick();
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    press(4'd5);
    for (int i = 0; i < 19; i++) begin
      tick();
      if (bus.timeout !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", early); end
    checks++; if (bus.bcd_packet !== 24'hAFFFFF) begin errors++; $display("FAIL to_before got %h want %h", bus.bcd_packet, 24'hAFFFFF); end
    tick();
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", bus.timeout); end
    checks++; if (bus.bcd_packet !== 24'hFFFFFF) begin errors++; $display("FAIL to_blank got %h want %h", bus.bcd_packet, 24'hFFFFFF); end
    tick();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_once got %b want 0", bus.timeout); end
    press(4'd5);
    idle(19);
    press(4'd6);
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_key_wins got %b want 0", bus.timeout); end
    checks++; if (bus.bcd_packet !== 24'h6AFFFF) begin errors++; $display("FAIL to_key_shown got %h want %h", bus.bcd_packet, 24'h6AFFFF); end
    tick();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_restart got %b want 0", bus.timeout); end
    press(4'hB);
    checks++; if ({bus.bcd_packet, bus.timeout, bus.pin_valid} !== {24'hFFFFFF, 2'b00}) begin errors++; $display("FAIL clear got %h/%b%b want ffffff/00", bus.bcd_packet, bus.timeout, bus.pin_valid); end
  endtask

  task automatic test_entry_en();
    logic fired;
    fired = 1'b0;
    press(4'd3);
    bus.entry_en = 1'b0;
    press(4'd4);
    checks++; if (bus.bcd_packet !== 24'h3FFFFF) begin errors++; $display("FAIL en_drop got %h want %h", bus.bcd_packet, 24'h3FFFFF); end
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.timeout !== 1'b0) fired = 1'b1;
    end
    checks++; if (fired !== 1'b0) begin errors++; $display("FAIL en_frozen_timeout got %b want 0", fired); end
    checks++; if (bus.bcd_packet !== 24'h3FFFFF) begin errors++; $display("FAIL en_frozen_mask got %h want %h", bus.bcd_packet, 24'h3FFFFF); end
    bus.entry_en = 1'b1;
    idle(3);
    checks++; if (bus.bcd_packet !== 24'h3FFFFF) begin errors++; $display("FAIL en_resume_raw got %h want %h", bus.bcd_packet, 24'h3FFFFF); end
    tick();
    checks++; if (bus.bcd_packet !== 24'hAFFFFF) begin errors++; $display("FAIL en_resume_mask got %h want %h", bus.bcd_packet, 24'hAFFFFF); end
    press(4'hB);
  endtask

  task automatic test_reset_mid_entry();
    press(4'd9);
    press(4'd9);
    press(4'd9);
    checks++; if (bus.bcd_packet !== 24'h9AAFFF) begin errors++; $display("FAIL rm_entry got %h want %h", bus.bcd_packet, 24'h9AAFFF); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.bcd_packet !== 24'hFFFFFF) begin errors++; $display("FAIL rm_async_bcd got %h want %h", bus.bcd_packet, 24'hFFFFFF); end
    checks++; if ({bus.disp_en, bus.pin_len} !== {1'b0, 3'd0}) begin errors++; $display("FAIL rm_async_en_len got %b/%0d want 0/0", bus.disp_en, bus.pin_len); end
    checks++; if (bus.pin_code !== 24'hFFFFFF) begin errors++; $display("FAIL rm_async_pin got %h want %h", bus.pin_code, 24'hFFFFFF); end
    tick();
    rst = 1'b1;
    tick();
    press(4'hC);
    checks++; if ({bus.pin_valid, bus.pin_reject, bus.timeout} !== 3'b000) begin errors++; $display("FAIL rm_idle_enter got %b want 000", {bus.pin_valid, bus.pin_reject, bus.timeout}); end
    checks++; if ({bus.bcd_packet, bus.disp_en} !== {24'hFFFFFF, 1'b1}) begin errors++; $display("FAIL rm_after got %h/%b want ffffff/1", bus.bcd_packet, bus.disp_en); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    clk           = 1'b0;
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.entry_en  = 1'b1;
    test_reset();
    test_valid_pin();
    test_reject_backspace();
    test_full_entry();
    test_timeout();
    test_entry_en();
    test_reset_mid_entry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
